// File: rtl/barrett_pkg.sv
// Shared constants and FSM state encoding for the Barrett parameter generator
// and the downstream 128->64-bit Barrett reducer.
package barrett_pkg;

  localparam int Q_W       = 64;
  localparam int Z_W       = 128;
  localparam int K_W       = 7;
  localparam int MU_W      = 65;
  localparam int DIV_STEPS = 129;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC_K = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/barrett_param_gen_clog2.sv
// Combinational bit length of a 64-bit value: index of the highest set bit
// plus one, or 0 for an all-zero input.
module clog2_64 (
  input  logic [63:0] val_i,
  output logic [6:0]  len_o
);

  // Priority scan from LSB upward so the highest set bit wins.
  always_comb begin
    len_o = 7'd0;
    for (int i = 0; i < 64; i++) begin
      if (val_i[i]) begin
        len_o = 7'(i + 1);
      end else begin
        len_o = len_o;
      end
    end
  end

endmodule

// File: rtl/barrett_param_gen.sv
// Computes k = ceil(log2(q)) and mu = floor(2^(2k)/q) with a bit-serial
// restoring divider; fixed 131-cycle latency from accepted start to done.
module barrett_param_gen #(
  parameter int Q_W = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [Q_W-1:0] q,
  output logic           busy,
  output logic           done,
  output logic [6:0]     k,
  output logic [Q_W:0]   mu,
  output logic           err
);

  import barrett_pkg::*;

  state_e         state_q, state_d;
  logic [Q_W-1:0] modq_q,  modq_d;
  logic [6:0]     kr_q,    kr_d;
  logic           errf_q,  errf_d;
  logic [Q_W-1:0] rem_q,   rem_d;
  logic [Q_W:0]   quo_q,   quo_d;
  logic [7:0]     cnt_q,   cnt_d;
  logic           busy_q,  busy_d;
  logic           done_q,  done_d;
  logic [6:0]     k_q,     k_d;
  logic [Q_W:0]   mu_q,    mu_d;
  logic           err_q,   err_d;

  logic [6:0]     clog_s;
  logic           dbit_s;
  logic [Q_W:0]   rem_s;
  logic [Q_W:0]   diff_s;
  logic           ge_s;

  // k is the bit length of q-1, so exact powers of two map to their own log.
  clog2_64 u_clog2 (
    .val_i (64'(modq_q - {{(Q_W-1){1'b0}}, 1'b1})),
    .len_o (clog_s)
  );

  // The dividend 2^(2k) has exactly one set bit, at position 2k.
  assign dbit_s = (cnt_q == {kr_q, 1'b0});
  assign rem_s  = {rem_q, dbit_s};
  assign diff_s = rem_s - {1'b0, modq_q};
  assign ge_s   = (rem_s >= {1'b0, modq_q});

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    modq_d  = modq_q;
    kr_d    = kr_q;
    errf_d  = errf_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    k_d     = k_q;
    mu_d    = mu_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          modq_d  = q;
          busy_d  = 1'b1;
          state_d = CALC_K;
        end else begin
          state_d = IDLE;
        end
      end
      CALC_K: begin
        if (modq_q == {Q_W{1'b0}}) begin
          errf_d = 1'b1;
          kr_d   = 7'd0;
        end else begin
          errf_d = 1'b0;
          kr_d   = clog_s;
        end
        rem_d   = {Q_W{1'b0}};
        quo_d   = {(Q_W+1){1'b0}};
        cnt_d   = 8'(2 * Q_W);
        state_d = DIV;
      end
      DIV: begin
        // The remainder stays below q, so it always fits in Q_W bits.
        if (ge_s) begin
          rem_d = diff_s[Q_W-1:0];
          quo_d = {quo_q[Q_W-1:0], 1'b1};
        end else begin
          rem_d = rem_s[Q_W-1:0];
          quo_d = {quo_q[Q_W-1:0], 1'b0};
        end
        if (cnt_q == 8'd0) begin
          state_d = FINISH;
        end else begin
          cnt_d   = cnt_q - 8'd1;
          state_d = DIV;
        end
      end
      FINISH: begin
        k_d     = kr_q;
        mu_d    = errf_q ? {(Q_W+1){1'b0}} : quo_q;
        err_d   = errf_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      modq_q  <= {Q_W{1'b0}};
      kr_q    <= 7'd0;
      errf_q  <= 1'b0;
      rem_q   <= {Q_W{1'b0}};
      quo_q   <= {(Q_W+1){1'b0}};
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      k_q     <= 7'd0;
      mu_q    <= {(Q_W+1){1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      modq_q  <= modq_d;
      kr_q    <= kr_d;
      errf_q  <= errf_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      k_q     <= k_d;
      mu_q    <= mu_d;
      err_q   <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign k    = k_q;
  assign mu   = mu_q;
  assign err  = err_q;

endmodule

// File: tb/tb_barrett_param_gen.sv
// Scoreboard bench for barrett_param_gen: expected results are queued at
// start and checked (values and latency) on every done pulse.
module tb_barrett_param_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] q;
  logic        busy;
  logic        done;
  logic [6:0]  k;
  logic [64:0] mu;
  logic        err;

  typedef struct {
    logic [6:0]  k;
    logic [64:0] mu;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  barrett_param_gen #(.Q_W(64)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .k     (k),
    .mu    (mu),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [63:0] qv);
    exp_t        e;
    logic [63:0] v;
    logic [128:0] num;
    e.k   = 7'd0;
    e.err = (qv == 64'd0);
    e.due = 0;
    v     = qv - 64'd1;
    if (qv != 64'd0)
      for (int i = 0; i < 64; i++)
        if (v[i]) e.k = 7'(i + 1);
    num  = 129'd1 << (2 * e.k);
    e.mu = (qv == 64'd0) ? 65'd0 : 65'(num / {65'd0, qv});
    return e;
  endfunction

  // Compare every done pulse against the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 65'(done), 65'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("k",       65'(k),   65'(e.k));
        chk("mu",      mu,       e.mu);
        chk("err",     65'(err), 65'(e.err));
        chk("latency", 65'(cyc), 65'(e.due));
      end
    end
  end

  task automatic do_start(input logic [63:0] qv, input logic [6:0] ek,
                          input logic [64:0] emu, input logic eerr);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    q     = qv;
    e.k = ek; e.mu = emu; e.err = eerr; e.due = cyc + 132;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    q     = 64'($urandom) ^ {32'($urandom), 32'd0};
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 65'(sb.size()), 65'd0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    exp_t e;
    rst   = 1'b1;
    start = 1'b0;
    q     = 64'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 65'(busy), 65'd0);
    chk("rst_done", 65'(done), 65'd0);
    chk("rst_k",    65'(k),    65'd0);
    chk("rst_mu",   mu,        65'd0);
    chk("rst_err",  65'(err),  65'd0);
    rst = 1'b0;
    @(negedge clk);

    // q=7 also checks the busy window length.
    do_start(64'd7, 7'd3, 65'd9, 1'b0);
    n = 0;
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", 65'(n), 65'd131);
    drain();

    do_start(64'd8, 7'd3, 65'd8, 1'b0);
    drain();
    do_start(64'd1, 7'd0, 65'd1, 1'b0);
    drain();
    do_start(64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 65'h1_0000_0000_0000_0001, 1'b0);
    drain();
    do_start(64'd0, 7'd0, 65'd0, 1'b1);
    drain();
    do_start(64'd7, 7'd3, 65'd9, 1'b0);
    drain();

    for (int r = 0; r < 3; r++) begin
      logic [63:0] rq;
      rq = {32'($urandom), 32'($urandom)} >> $urandom_range(0, 60);
      e  = model(rq);
      do_start(rq, e.k, e.mu, e.err);
      drain();
    end

    // Start while busy is ignored; start in the done cycle is accepted.
    do_start(64'd7, 7'd3, 65'd9, 1'b0);
    repeat (10) @(negedge clk);
    start = 1'b1;
    q     = 64'd5;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 65'(done), 65'd1);
    start = 1'b1;
    q     = 64'd5;
    e.k = 7'd3; e.mu = 65'd12; e.err = 1'b0; e.due = cyc + 132;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (150) @(negedge clk);

    // Reset mid-run aborts without a done pulse.
    do_start(64'd7, 7'd3, 65'd9, 1'b0);
    repeat (48) @(negedge clk);
    sb.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 65'(busy), 65'd0);
    chk("abort_done", 65'(done), 65'd0);
    chk("abort_k",    65'(k),    65'd0);
    chk("abort_mu",   mu,        65'd0);
    chk("abort_err",  65'(err),  65'd0);
    repeat (150) @(negedge clk);
    do_start(64'd8, 7'd3, 65'd8, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
